// File: rtl/reflet_boot_pkg.sv
// reflet_boot_pkg: shared boot-loader state encoding, default image geometry and header magic
package reflet_boot_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, COPY, DONE, ERROR} state_t;
  localparam int DEF_HDR_LEN = 4;
  localparam int DEF_COPY_LEN = 60;
  localparam logic [7:0] MAGIC0 = 8'h41;
  localparam logic [7:0] MAGIC1 = 8'h53;
  localparam logic [7:0] MAGIC2 = 8'h52;
  localparam logic [7:0] MAGIC3 = 8'h4D;
  function automatic logic [7:0] magic_byte(input int i);
    return i == 0 ? MAGIC0 : i == 1 ? MAGIC1 : i == 2 ? MAGIC2 : MAGIC3;
  endfunction
endpackage

// File: rtl/rom_boot_loader.sv
// rom_boot_loader: checks the "ASRM" header of a boot ROM and copies its payload into program RAM
// Ports: clk/reset (async active-low); rom_addr/rom_en/rom_data ROM read side (data one cycle late);
// ram_addr/ram_data/ram_we RAM write side; reload restarts from DONE/ERROR;
// cpu_rst_n releases the CPU once done; done/error report the load result.
module rom_boot_loader
  import reflet_boot_pkg::*;
#(
  parameter int ROM_AW = 6,
  parameter int RAM_AW = 8,
  parameter int HDR_LEN = DEF_HDR_LEN,
  parameter int COPY_LEN = DEF_COPY_LEN
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_en,
  input  logic [7:0]        rom_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  input  logic              reload,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);
  localparam int N = HDR_LEN + COPY_LEN;
  localparam int CW = $clog2(N + 1);
  state_t st, st_nxt;
  logic [CW-1:0] cnt, idx;
  logic busy;
  // cnt is the address being presented; idx is the byte whose data arrives this cycle
  assign idx = cnt - CW'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      cnt <= '0;
    end else begin
      st <= st_nxt;
      cnt <= (busy && (st_nxt == CHECK || st_nxt == COPY)) ? cnt + CW'(1) : '0;
    end
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: st_nxt = CHECK;
      CHECK:
        if (cnt != '0 && rom_data != magic_byte(int'(idx))) st_nxt = ERROR;
        else if (cnt == CW'(HDR_LEN)) st_nxt = COPY;
      COPY: if (cnt == CW'(N)) st_nxt = DONE;
      default: if (reload) st_nxt = CHECK;
    endcase
  end
  always_comb begin
    busy = st == CHECK || st == COPY;
    rom_en = busy;
    // the final busy cycle only waits for the last byte, so the address holds rather than wrapping
    rom_addr = busy ? (cnt < CW'(N) ? ROM_AW'(cnt) : ROM_AW'(N - 1)) : '0;
    ram_we = st == COPY;
    ram_addr = ram_we ? RAM_AW'(idx - CW'(HDR_LEN)) : '0;
    ram_data = ram_we ? rom_data : '0;
    done = st == DONE;
    cpu_rst_n = st == DONE;
    error = st == ERROR;
  end
endmodule

// File: doc/rom_boot_loader.md
ROM_BOOT_LOADER -- requirements
Module: rom_boot_loader

Interface
REQ-001 SHALL have parameter ROM_AW, default 6, ROM address width.
REQ-002 SHALL have parameter RAM_AW, default 8, program-RAM address width.
REQ-003 SHALL have parameter HDR_LEN, default 4, header byte count.
REQ-004 SHALL have parameter COPY_LEN, default 60, payload byte count (ROM bytes HDR_LEN..HDR_LEN+COPY_LEN-1).
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rom_addr, output, ROM_AW, ROM byte address.
REQ-008 SHALL have port rom_en, output, 1, ROM output enable (enable_out).
REQ-009 SHALL have port rom_data, input, 8, ROM read data, valid one cycle after rom_addr is presented.
REQ-010 SHALL have port ram_addr, output, RAM_AW, program-RAM write address.
REQ-011 SHALL have port ram_data, output, 8, program-RAM write data.
REQ-012 SHALL have port ram_we, output, 1, RAM write strobe; RAM writes on the edge ending a cycle with ram_we high.
REQ-013 SHALL have port reload, input, 1, level-sampled restart request.
REQ-014 SHALL have port cpu_rst_n, output, 1, CPU hold-in-reset, active low.
REQ-015 SHALL have port done, output, 1, image copied successfully.
REQ-016 SHALL have port error, output, 1, header mismatch.

Function
REQ-017 SHALL implement states IDLE, CHECK, COPY, DONE, ERROR; IDLE only on reset.
REQ-018 SHALL move IDLE->CHECK on first rising edge with reset high; C1 = cycle after that edge.
REQ-019 SHALL drive rom_addr=a in cycle C1+a for a=0..HDR_LEN+COPY_LEN-1, one address per cycle, no stalls.
REQ-020 SHALL hold rom_en high in cycles C1..C1+HDR_LEN+COPY_LEN, low in all other states.
REQ-021 SHALL compare byte b (sampled at end of C1+b+1), b<HDR_LEN, against magic "ASRM" (0x41,0x53,0x52,0x4D, byte 0 first).
REQ-022 SHALL on first mismatch at byte b enter ERROR; error and rom_en low/high per state from C1+b+2; no ram_we ever asserted in that load.
REQ-023 SHALL enter COPY after byte HDR_LEN-1 matches, with no idle cycle in the address stream.
REQ-024 SHALL for payload byte b drive ram_we=1, ram_addr=b-HDR_LEN, ram_data=rom_data combinationally in cycle C1+b+1.
REQ-025 SHALL assert exactly COPY_LEN write strobes per successful load, ram_addr strictly incrementing from 0.
REQ-026 SHALL enter DONE after the last payload write; done=1, cpu_rst_n=1 from cycle C1+HDR_LEN+COPY_LEN+1.
REQ-027 SHALL keep cpu_rst_n=0 in every state except DONE.
REQ-028 SHALL on reload=1 in DONE or ERROR restart CHECK next cycle (new C1), clearing done/error and driving cpu_rst_n=0.
REQ-029 SHALL ignore reload in CHECK and COPY.
REQ-030 SHALL size the internal byte counter to cover HDR_LEN+COPY_LEN without wrap; rom_addr never wraps past 2^ROM_AW-1.
REQ-031 SHALL drive ram_addr/ram_data to 0 whenever ram_we=0.

Reset
REQ-032 SHALL on reset low, immediately and regardless of state: state=IDLE, rom_addr=0, rom_en=0, ram_we=0, ram_addr=0, cpu_rst_n=0, done=0, error=0.
REQ-033 SHALL after reset mid-CHECK/COPY restart the full load from byte 0; partial RAM contents are overwritten.

Structure
REQ-034 SHALL place the state enum, magic byte constants and default HDR_LEN/COPY_LEN in shared package reflet_boot_pkg.
REQ-035 SHALL be a single module with no sub-module; it connects directly to rom1-style ROMs (rom_en to enable_out).

Verification
REQ-036 SHALL cover good image (rom01 contents) -> 60 writes, ram[0]=0x16, ram[0x29]=0x0E, ram[0x3B]=0x00, done and cpu_rst_n high at C1+65.
REQ-037 SHALL cover ROM byte 1 = 0x00 -> error high from C1+3, rom_en low from C1+3, zero ram_we, cpu_rst_n stays 0.
REQ-038 SHALL cover reset low in C1+20 (mid-COPY) -> all outputs at reset values same cycle; after release full 60-write load completes.
REQ-039 SHALL cover reload pulse in DONE -> cpu_rst_n low next cycle, second identical 60-write sequence, done again after 65 cycles.
REQ-040 SHALL cover reload held high through CHECK/COPY -> sequence unaffected; with reload still high in DONE, restart occurs one cycle after DONE entry.
REQ-041 SHALL cover reload in ERROR with corrected ROM -> successful load, error cleared in first CHECK cycle.
